id_hazard_ctrl: RTL and testbench

//  Hazard, forwarding and PC-select controller for the ID stage.
//  - Decodes the instruction held in ID.
//  - Drives the ID branch-forward mux selects and the PC-source select.
//  - Detects data hazards against the EX and MEM stages and sequences multi-cycle stalls with a down-counter.
//  - Generates the IF flush and the ID/EX bubble.
//  - Keeps saturating stall and flush performance counters.

---
 rtl/id_hazard_ctrl.sv | 97 +++++++++
 tb/tb_id_hazard_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage hazard detection, branch forwarding, PC-select and stall/flush sequencing.
//   clk, rst_n                        clock, asynchronous active-low reset
//   id_valid, id_opcode, id_funct,    instruction held in ID
//   id_rs, id_rt, cmp_eq              its source registers and the ID comparator result
//   ex_rd/_regwrite/_memread          EX-stage destination and type
//   mem_rd/_regwrite/_memread         MEM-stage destination and type
//   wb_rd, wb_regwrite                write-back destination and enable
//   forbranch_a, forbranch_b          rs/rt branch-operand mux selects
//   pc_src, pc_write, ifid_write      PC select and front-end enables
//   if_flush, idex_bubble             IF/ID flush and ID/EX NOP insertion
//   stall_cycles, flush_count         saturating performance counters
module id_hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [5:0]       id_opcode,
   input  logic [5:0]       id_funct,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             cmp_eq,
   input  logic [4:0]       ex_rd,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic [4:0]       mem_rd,
   input  logic             mem_regwrite,
   input  logic             mem_memread,
   input  logic [4:0]       wb_rd,
   input  logic             wb_regwrite,
   output logic [1:0]       forbranch_a,
   output logic [1:0]       forbranch_b,
   output logic [1:0]       pc_src,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             if_flush,
   output logic             idex_bubble,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);
   localparam logic [5:0] OP_J = 6'b000010;
   localparam logic [5:0] OP_JAL = 6'b000011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;
   localparam logic [5:0] FN_JR = 6'b001000;
   logic is_beq, is_bne, is_jmp, is_jr, is_br, use_rs, use_rt;
   logic m_ex, m_mem, stall, take;
   logic [1:0] cnt, need;
   function automatic logic match(input logic [4:0] r, input logic [4:0] d);
      return r != 5'd0 && r == d;
   endfunction
   assign is_beq = id_opcode == OP_BEQ;
   assign is_bne = id_opcode == OP_BNE;
   assign is_jmp = id_opcode == OP_J || id_opcode == OP_JAL;
   assign is_jr = id_opcode == 6'd0 && id_funct == FN_JR;
   assign is_br = is_beq | is_bne | is_jr;
   // jumps read no registers; jr reads only rs; everything else may read both
   assign use_rs = !is_jmp;
   assign use_rt = is_beq | is_bne | (!is_br && !is_jmp);
   assign m_ex = (use_rs && match(id_rs, ex_rd)) || (use_rt && match(id_rt, ex_rd));
   assign m_mem = (use_rs && match(id_rs, mem_rd)) || (use_rt && match(id_rt, mem_rd));
   // a load in EX feeding a branch needs two cycles: one to reach MEM, one to reach WB
   always_comb begin
      need = 2'd0;
      if (id_valid && cnt == 2'd0)
         need = is_br ? ((ex_memread && m_ex) ? 2'd2 :
                         ((ex_regwrite && m_ex) || (mem_memread && m_mem)) ? 2'd1 : 2'd0)
                      : ((ex_memread && m_ex) ? 2'd1 : 2'd0);
   end
   // everything is held at its idle value while reset is asserted
   assign stall = rst_n && (cnt != 2'd0 || need != 2'd0);
   assign take = rst_n && id_valid && !stall &&
                 ((is_beq && cmp_eq) || (is_bne && !cmp_eq) || is_jmp || is_jr);
   assign pc_src = !take ? 2'b00 : is_jr ? 2'b11 : is_jmp ? 2'b01 : 2'b10;
   assign if_flush = take;
   assign pc_write = !stall;
   assign ifid_write = !stall;
   assign idex_bubble = stall;
   // a load still in MEM has no data yet, so only non-load MEM results forward
   assign forbranch_a = !rst_n ? 2'b00 :
                        (mem_regwrite && !mem_memread && match(id_rs, mem_rd)) ? 2'b10 :
                        (wb_regwrite && match(id_rs, wb_rd)) ? 2'b01 : 2'b00;
   assign forbranch_b = !rst_n ? 2'b00 :
                        (mem_regwrite && !mem_memread && match(id_rt, mem_rd)) ? 2'b10 :
                        (wb_regwrite && match(id_rt, wb_rd)) ? 2'b01 : 2'b00;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 2'd0;
         stall_cycles <= '0;
         flush_count <= '0;
      end else begin
         cnt <= cnt != 2'd0 ? cnt - 2'd1 : need != 2'd0 ? need - 2'd1 : 2'd0;
         if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
         if (if_flush && flush_count != '1) flush_count <= flush_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: vector table, hand sequences and randomized model check for id_hazard_ctrl.
module tb_id_hazard_ctrl;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;
   logic clk = 1'b0, rst_n = 1'b0;
   logic id_valid, cmp_eq, ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;
   logic [5:0] id_opcode, id_funct;
   logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
   logic [1:0] forbranch_a, forbranch_b, pc_src;
   logic pc_write, ifid_write, if_flush, idex_bubble;
   logic [CW-1:0] stall_cycles, flush_count;
   int n_chk = 0, n_fail = 0;
   typedef struct {
      int v, op, fn, rs, rt, cmp, exd, exw, exm, mmd, mmw, mmm, wbd, wbw;
      int fa, fb, pc, pcw, fl, bb;
   } vec_t;
   vec_t tbl[10];
   id_hazard_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
      .id_rs(id_rs), .id_rt(id_rt), .cmp_eq(cmp_eq), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
      .mem_memread(mem_memread), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .forbranch_a(forbranch_a), .forbranch_b(forbranch_b), .pc_src(pc_src),
      .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush),
      .idex_bubble(idex_bubble), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask
   task automatic drive(input vec_t t);
      id_valid = t.v[0]; id_opcode = t.op[5:0]; id_funct = t.fn[5:0];
      id_rs = t.rs[4:0]; id_rt = t.rt[4:0]; cmp_eq = t.cmp[0];
      ex_rd = t.exd[4:0]; ex_regwrite = t.exw[0]; ex_memread = t.exm[0];
      mem_rd = t.mmd[4:0]; mem_regwrite = t.mmw[0]; mem_memread = t.mmm[0];
      wb_rd = t.wbd[4:0]; wb_regwrite = t.wbw[0];
   endtask
   task automatic idle();
      drive(vec_t'{0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0});
   endtask
   task automatic rst_pulse();
      rst_n = 1'b0; #1; rst_n = 1'b1;
   endtask
   // stall need derived directly from the hazard rules, per used source register
   function automatic int need_f();
      bit br, jmp;
      int n, r;
      br = id_opcode == 4 || id_opcode == 5 || (id_opcode == 0 && id_funct == 8);
      jmp = id_opcode == 2 || id_opcode == 3;
      n = 0;
      for (int k = 0; k < 2; k++) begin
         r = k == 0 ? int'(id_rs) : int'(id_rt);
         if (k == 0 && jmp) continue;
         if (k == 1 && !(id_opcode == 4 || id_opcode == 5 || (!br && !jmp))) continue;
         if (r == 0) continue;
         if (r == ex_rd && ex_memread) n = (br && n < 2) ? 2 : (n < 1 ? 1 : n);
         else if (r == ex_rd && ex_regwrite && br && n < 1) n = 1;
         if (br && r == mem_rd && mem_memread && n < 1) n = 1;
      end
      return n;
   endfunction
   function automatic int fwd_f(input int r);
      if (r == 0) return 0;
      if (mem_regwrite && !mem_memread && r == mem_rd) return 2;
      if (wb_regwrite && r == wb_rd) return 1;
      return 0;
   endfunction
   initial begin
      int pend, sc, fc, nd, st, pc;
      int ops[7];
      tbl[0] = vec_t'{1,4,0,1,2,1, 1,1,0, 0,0,0, 0,0, 0,0,0,0,0,1};
      tbl[1] = vec_t'{1,4,0,1,2,1, 0,0,0, 1,1,0, 0,0, 2,0,2,1,1,0};
      tbl[2] = vec_t'{1,0,8,31,0,0, 0,0,0, 0,0,0, 31,1, 1,0,3,1,1,0};
      tbl[3] = vec_t'{1,4,0,0,0,1, 0,1,1, 0,0,0, 0,0, 0,0,2,1,1,0};
      tbl[4] = vec_t'{1,2,0,5,0,0, 5,1,1, 0,0,0, 0,0, 0,0,1,1,1,0};
      tbl[5] = vec_t'{1,5,0,6,7,1, 0,0,0, 0,0,0, 0,0, 0,0,0,1,0,0};
      tbl[6] = vec_t'{1,4,0,2,4,0, 0,0,0, 4,1,1, 4,1, 0,1,0,0,0,1};
      tbl[7] = vec_t'{1,0,32,3,5,0, 0,0,0, 3,1,1, 0,0, 0,0,0,1,0,0};
      tbl[8] = vec_t'{0,4,0,1,2,1, 1,1,1, 0,0,0, 0,0, 0,0,0,1,0,0};
      tbl[9] = vec_t'{1,3,0,0,2,0, 0,0,0, 0,0,0, 2,1, 0,1,1,1,1,0};
      ops = '{4, 5, 2, 3, 0, 35, 8};
      // reset state, with a hazard presented on the inputs
      drive(tbl[0]);
      @(negedge clk); #1;
      chk("rst_pc_write", pc_write, 1); chk("rst_bubble", idex_bubble, 0);
      chk("rst_flush", if_flush, 0); chk("rst_pc_src", pc_src, 0);
      chk("rst_fa", forbranch_a, 0); chk("rst_stall_cnt", stall_cycles, 0);
      chk("rst_flush_cnt", flush_count, 0);
      rst_n = 1'b1;
      // combinational vector table, cnt cleared before each entry
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(tbl[i]); #1;
         chk($sformatf("v%0d_fa", i), forbranch_a, tbl[i].fa);
         chk($sformatf("v%0d_fb", i), forbranch_b, tbl[i].fb);
         chk($sformatf("v%0d_pc_src", i), pc_src, tbl[i].pc);
         chk($sformatf("v%0d_pc_write", i), pc_write, tbl[i].pcw);
         chk($sformatf("v%0d_ifid_write", i), ifid_write, tbl[i].pcw);
         chk($sformatf("v%0d_flush", i), if_flush, tbl[i].fl);
         chk($sformatf("v%0d_bubble", i), idex_bubble, tbl[i].bb);
         rst_pulse();
      end
      // EX add r1, ID beq r1,r2: one stall, then MEM forward and taken branch
      @(negedge clk); rst_pulse();
      drive(tbl[0]); #1;
      chk("s1_pc_write", pc_write, 0); chk("s1_bubble", idex_bubble, 1);
      @(negedge clk);
      drive(tbl[1]); #1;
      chk("s1_fa", forbranch_a, 2); chk("s1_pc_src", pc_src, 2); chk("s1_flush", if_flush, 1);
      @(negedge clk); idle(); #1;
      chk("s1_stall_cnt", stall_cycles, 1); chk("s1_flush_cnt", flush_count, 1);
      // EX lw r3, ID bne r3,r0: exactly two stalls, then WB forward
      @(negedge clk); rst_pulse();
      drive(vec_t'{1,5,0,3,0,0, 3,1,1, 0,0,0, 0,0, 0,0,0,0,0,0}); #1;
      chk("s2_stall0", pc_write, 0);
      @(negedge clk);
      drive(vec_t'{1,5,0,3,0,0, 0,0,0, 3,1,1, 0,0, 0,0,0,0,0,0}); #1;
      chk("s2_stall1", pc_write, 0); chk("s2_bubble1", idex_bubble, 1);
      @(negedge clk);
      drive(vec_t'{1,5,0,3,0,0, 0,0,0, 0,0,0, 3,1, 0,0,0,0,0,0}); #1;
      chk("s2_release", pc_write, 1); chk("s2_fa", forbranch_a, 1); chk("s2_pc_src", pc_src, 2);
      @(negedge clk); idle(); #1;
      chk("s2_stall_cnt", stall_cycles, 2);
      // EX lw r3, ID add r4,r3,r5: one stall, no flush
      @(negedge clk); rst_pulse();
      drive(vec_t'{1,0,32,3,5,0, 3,1,1, 0,0,0, 0,0, 0,0,0,0,0,0}); #1;
      chk("s3_stall", pc_write, 0);
      @(negedge clk);
      drive(vec_t'{1,0,32,3,5,0, 0,0,0, 3,1,1, 0,0, 0,0,0,0,0,0}); #1;
      chk("s3_release", pc_write, 1); chk("s3_fa", forbranch_a, 0);
      chk("s3_pc_src", pc_src, 0); chk("s3_flush", if_flush, 0);
      // jr r31 with r31 in WB: forward, jump-register, flush counted
      @(negedge clk); rst_pulse();
      drive(tbl[2]); #1;
      chk("s4_fa", forbranch_a, 1); chk("s4_pc_src", pc_src, 3); chk("s4_stall", pc_write, 1);
      @(negedge clk); idle(); #1;
      chk("s4_flush_cnt", flush_count, 1);
      // reset asserted during the second cycle of a two-cycle stall
      @(negedge clk); rst_pulse();
      drive(vec_t'{1,5,0,3,0,0, 3,1,1, 0,0,0, 0,0, 0,0,0,0,0,0});
      @(negedge clk); #1;
      chk("s5_midstall", pc_write, 0); chk("s5_cnt_before", stall_cycles, 1);
      rst_n = 1'b0; #1;
      chk("s5_rst_pc_write", pc_write, 1); chk("s5_rst_cnt", stall_cycles, 0);
      idle(); rst_n = 1'b1; #1;
      chk("s5_release", pc_write, 1);
      @(negedge clk); #1;
      chk("s5_no_residual", pc_write, 1); chk("s5_cnt_after", stall_cycles, 0);
      // randomized run against the rule model; narrow register range keeps hazards frequent
      @(negedge clk); rst_pulse();
      pend = 0; sc = 0; fc = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         id_valid = ($urandom_range(0, 9) != 0);
         id_opcode = 6'(ops[$urandom_range(0, 6)]);
         id_funct = ($urandom_range(0, 1) != 0) ? 6'd8 : 6'd32;
         id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
         cmp_eq = 1'($urandom);
         ex_rd = 5'($urandom_range(0, 3)); ex_regwrite = 1'($urandom); ex_memread = 1'($urandom);
         mem_rd = 5'($urandom_range(0, 3)); mem_regwrite = 1'($urandom); mem_memread = 1'($urandom);
         wb_rd = 5'($urandom_range(0, 3)); wb_regwrite = 1'($urandom);
         #1;
         nd = (id_valid && pend == 0) ? need_f() : 0;
         st = (pend > 0 || nd > 0) ? 1 : 0;
         pc = 0;
         if (id_valid && !st) begin
            if ((id_opcode == 4 && cmp_eq) || (id_opcode == 5 && !cmp_eq)) pc = 2;
            else if (id_opcode == 2 || id_opcode == 3) pc = 1;
            else if (id_opcode == 0 && id_funct == 8) pc = 3;
         end
         chk("r_fa", forbranch_a, fwd_f(id_rs)); chk("r_fb", forbranch_b, fwd_f(id_rt));
         chk("r_pc_src", pc_src, pc); chk("r_pc_write", pc_write, 1 - st);
         chk("r_ifid_write", ifid_write, 1 - st); chk("r_bubble", idex_bubble, st);
         chk("r_flush", if_flush, pc != 0 ? 1 : 0);
         chk("r_stall_cnt", stall_cycles, sc); chk("r_flush_cnt", flush_count, fc);
         pend = pend > 0 ? pend - 1 : (nd > 0 ? nd - 1 : 0);
         if (st && sc < CMAX) sc++;
         if (pc != 0 && fc < CMAX) fc++;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
